// File: rtl/rotr_64b_iter.sv
`default_nettype none
// ============================================================================
//  Module      : rotr_64b_iter
//  Description : Iterative circular rotate-right unit. The fine part of the
//                shift (shift mod STEP) is applied on accept; the coarse part
//                is applied as STEP-bit rotations, one per cycle. The result
//                is offered with a valid/ready handshake.
//
//  Ports       : clk_i        - clock, rising edge
//                rst_n_i      - asynchronous active-low reset
//                in_data_i    - operand to rotate right
//                in_valid_i   - operand and shift_i valid
//                in_ready_o   - operand accepted this cycle when valid
//                shift_i      - rotate-right amount, sampled on accept
//                out_data_o   - rotated result
//                out_valid_o  - out_data_o holds a finished result
//                out_ready_i  - consumer takes the result this cycle
//
//  Revision    : 1.0 - initial release
// ============================================================================
module rotr_64b_iter #(
    parameter int D_WIDTH = 64,
    parameter int STEP    = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [D_WIDTH-1:0]         in_data_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [$clog2(D_WIDTH)-1:0] shift_i,
    output logic [D_WIDTH-1:0]         out_data_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i
);

    localparam int SW       = $clog2(D_WIDTH);
    localparam int LOG_STEP = $clog2(STEP);
    // Counter holds shift_i / STEP, at most D_WIDTH/STEP - 1.
    localparam int CW       = SW - LOG_STEP;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [D_WIDTH-1:0] r_work;
    logic [CW-1:0]      r_cnt;

    logic               w_accept;
    logic               w_iter;
    logic [SW-1:0]      w_fine;
    logic [CW-1:0]      w_coarse;
    logic [D_WIDTH-1:0] w_rot_in;
    logic [D_WIDTH-1:0] w_rot_step;

    // Split the shift into a sub-STEP remainder and a STEP multiple.
    assign w_fine   = shift_i & SW'(STEP - 1);
    assign w_coarse = CW'(shift_i >> LOG_STEP);

    // Shifting the doubled operand and keeping the low half gives a
    // circular rotation without losing any bit.
    assign w_rot_in   = D_WIDTH'({in_data_i, in_data_i} >> w_fine);
    assign w_rot_step = {r_work[STEP-1:0], r_work[D_WIDTH-1:STEP]};

    assign w_accept = in_valid_i && in_ready_o;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (w_coarse == '0) ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // A new accept here retires the current result on the same
                // edge, so there is no idle bubble between operations.
                if (w_accept) begin
                    w_state_nxt = (w_coarse == '0) ? S_DONE : S_BUSY;
                end else if (out_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        w_iter      = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready_o = 1'b1;
            end
            S_BUSY: begin
                w_iter = 1'b1;
            end
            S_DONE: begin
                in_ready_o  = out_ready_i;
                out_valid_o = 1'b1;
            end
            default: begin
                in_ready_o = 1'b0;
            end
        endcase
    end

    assign out_data_o = r_work;

    // ------------------------------------------------------------------
    // Working register and iteration counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_work <= '0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_work <= w_rot_in;
            r_cnt  <= w_coarse;
        end else if (w_iter) begin
            r_work <= w_rot_step;
            r_cnt  <= r_cnt - CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: doc/rotr_64b_iter.md
ROTR_64B_ITER -- requirements
Module: rotr_64b_iter

Interface
REQ-001 SHALL have parameter D_WIDTH, default 64: data width; power of two, >= 8.
REQ-002 SHALL have parameter STEP, default 8: bits rotated per iteration cycle; power of two, 1..D_WIDTH/2.
REQ-003 SHALL have port clk_i  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n_i  input  1  reset; asynchronous assert, active-low.
REQ-005 SHALL have port in_data_i  input  D_WIDTH  operand to rotate right.
REQ-006 SHALL have port in_valid_i  input  1  operand and shift_i valid.
REQ-007 SHALL have port in_ready_o  output  1  block accepts an operand this cycle.
REQ-008 SHALL have port shift_i  input  $clog2(D_WIDTH)  rotate-right amount; sampled only on accept.
REQ-009 SHALL have port out_data_o  output  D_WIDTH  rotated result.
REQ-010 SHALL have port out_valid_o  output  1  out_data_o holds a finished result.
REQ-011 SHALL have port out_ready_i  input  1  consumer takes the result this cycle.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 SHALL accept an operand when in_valid_i && in_ready_o at the clock edge.
REQ-014 SHALL drive in_ready_o = (state==IDLE) || (state==DONE && out_ready_i).
REQ-015 On accept, SHALL load the working register with in_data_i rotated right by (shift_i mod STEP) and load the iteration counter with shift_i / STEP.
REQ-016 On accept, SHALL go to DONE if the loaded count is 0, otherwise to BUSY.
REQ-017 In BUSY, each cycle SHALL rotate the working register right by STEP and decrement the counter; at count 1 SHALL go to DONE.
REQ-018 SHALL drive out_valid_o = (state==DONE) and out_data_o = working register.
REQ-019 Latency: accept at edge N -> out_valid_o high after edge N+1+(shift_i/STEP). With defaults: shift 0..7 gives 1 cycle, shift 63 gives 8 cycles.
REQ-020 In DONE with out_ready_i low, SHALL hold out_data_o and out_valid_o stable, with in_ready_o low.
REQ-021 In DONE with out_ready_i high and no accept, SHALL go to IDLE.
REQ-022 In DONE with out_ready_i high and in_valid_i high, SHALL complete the result and accept the new operand on the same edge, with no bubble cycle.
REQ-023 SHALL ignore in_valid_i, in_data_i and shift_i while in BUSY.
REQ-024 shift_i = 0 SHALL return in_data_i unchanged.
REQ-025 Result SHALL equal the full-width circular right rotation: bits shifted out at bit 0 re-enter at bit D_WIDTH-1; no bit lost for any shift 0..D_WIDTH-1.

Reset
REQ-026 While rst_n_i is low, SHALL force state IDLE, working register 0, counter 0, out_valid_o 0, out_data_o 0, in_ready_o 1.
REQ-027 Reset asserted in BUSY or DONE SHALL abort the operation; no result SHALL appear after release.
REQ-028 The first accept after reset release SHALL be possible on the first rising edge.

Verification
REQ-029 in_data_i=0x0123456789ABCDEF, shift_i=4, out_ready_i=1 -> out_data_o=0xF0123456789ABCDE, out_valid_o high 1 cycle after accept.
REQ-030 in_data_i=0x8000000000000001, shift_i=63 -> out_data_o=0x0000000000000003, out_valid_o high exactly 8 cycles after accept, in_ready_o low while in BUSY.
REQ-031 shift_i=0, in_data_i=0xDEADBEEFCAFEF00D -> identical value returned after 1 cycle; shift_i=8 -> 0x0DDEADBEEFCAFEF0 after 2 cycles.
REQ-032 out_ready_i low for 5 cycles in DONE -> out_data_o and out_valid_o stable, in_ready_o 0; then out_ready_i=1 with in_valid_i=1 -> result consumed and new operand accepted on the same edge.
REQ-033 rst_n_i pulsed low in BUSY (shift_i=40) -> outputs go 0 asynchronously, state IDLE, no out_valid_o pulse after release.
REQ-034 Random stream with random in_valid_i/out_ready_i -> every result equals the reference rotate-right model; results appear in order; none dropped or duplicated.
